// File: rtl/mem_access_stage.sv
// mem_access_stage: MEM stage, word load/store over a req/ready data bus.
// Ports: EX/MEM inputs (*_MEM), dmem_* bus, stall_mem, mem_err, MEM/WB outputs (*_WB).
module mem_access_stage #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] alu_MEM,
  input  logic [31:0] writedata_MEM,
  input  logic [4:0]  rd_MEM,
  input  logic        memread_MEM,
  input  logic        memwrite_MEM,
  input  logic        memtoreg_MEM,
  input  logic        regwrite_MEM,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ready,
  input  logic [31:0] dmem_rdata,
  output logic        stall_mem,
  output logic        mem_err,
  output logic [31:0] readdata_WB,
  output logic [31:0] alu_WB,
  output logic [4:0]  rd_WB,
  output logic        memtoreg_WB,
  output logic        regwrite_WB
);

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  typedef enum logic {IDLE, WAIT} state_t;

  state_t      state_q, state_d;
  logic [7:0]  cnt_q;
  logic        req_q, we_q, err_q;
  logic [31:0] addr_q, wdata_q;
  logic [31:0] readdata_q, alu_q;
  logic [4:0]  rd_q;
  logic        memtoreg_q, regwrite_q;

  logic acc, mis;
  logic go, pass, done, tmo, hold;

  assign acc = memread_MEM | memwrite_MEM;
  assign mis = acc & (alu_MEM[1:0] != 2'b00);

  // Exactly one of these is true every cycle.
  assign go   = (state_q == IDLE) & acc & ~mis;
  assign pass = (state_q == IDLE) & ~go;
  assign done = (state_q == WAIT) & dmem_ready;
  assign tmo  = (state_q == WAIT) & ~dmem_ready
              & (cnt_q == CNT_LAST);
  assign hold = (state_q == WAIT) & ~dmem_ready & ~tmo;

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (1'b1)
      go:          state_d = WAIT;
      done || tmo: state_d = IDLE;
      default:     state_d = state_q;
    endcase
  end

  always_comb begin
    stall_mem = go | hold;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q      <= '0;
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      err_q      <= 1'b0;
      readdata_q <= '0;
      alu_q      <= '0;
      rd_q       <= '0;
      memtoreg_q <= 1'b0;
      regwrite_q <= 1'b0;
    end else begin
      err_q <= 1'b0;
      unique case (1'b1)
        go: begin
          req_q      <= 1'b1;
          we_q       <= memwrite_MEM;
          addr_q     <= alu_MEM;
          wdata_q    <= writedata_MEM;
          cnt_q      <= '0;
          memtoreg_q <= 1'b0;
          regwrite_q <= 1'b0;
        end
        pass: begin
          // Misaligned accesses are squashed but still flow to WB.
          alu_q      <= alu_MEM;
          rd_q       <= rd_MEM;
          readdata_q <= '0;
          err_q      <= mis;
          memtoreg_q <= memtoreg_MEM & ~mis;
          regwrite_q <= regwrite_MEM & ~mis;
        end
        done: begin
          req_q      <= 1'b0;
          we_q       <= 1'b0;
          alu_q      <= alu_MEM;
          rd_q       <= rd_MEM;
          readdata_q <= memread_MEM ? dmem_rdata : '0;
          memtoreg_q <= memtoreg_MEM;
          regwrite_q <= regwrite_MEM;
        end
        tmo: begin
          req_q      <= 1'b0;
          we_q       <= 1'b0;
          err_q      <= 1'b1;
          memtoreg_q <= 1'b0;
          regwrite_q <= 1'b0;
        end
        hold: begin
          cnt_q <= cnt_q + 8'd1;
        end
        default: ;
      endcase
    end
  end

  assign dmem_req    = req_q;
  assign dmem_we     = we_q;
  assign dmem_addr   = addr_q;
  assign dmem_wdata  = wdata_q;
  assign mem_err     = err_q;
  assign readdata_WB = readdata_q;
  assign alu_WB      = alu_q;
  assign rd_WB       = rd_q;
  assign memtoreg_WB = memtoreg_q;
  assign regwrite_WB = regwrite_q;

endmodule
